// File: rtl/effect_param_bank_controller_if.sv
// Bundle of key inputs and parameter-bank outputs for effect_param_bank_controller.
//   master : drives the raw keys, observes the bank (board / bench side)
//   slave  : the controller itself
// Signals:
//   key_up, key_dn, key_sel : raw active-low keys
//   value_flat              : all parameters, param i at [i*W +: W]
//   sel                     : selected parameter index
//   gain_num, gain_den      : selected value and constant denominator
//   update                  : one-cycle pulse when a parameter or sel changes
interface effect_param_bank_controller_if #(
  parameter int unsigned N_PARAMS = 4,
  parameter int unsigned W        = 16
);
  localparam int unsigned SW = (N_PARAMS > 1) ? $clog2(N_PARAMS) : 1;

  logic                  key_up;
  logic                  key_dn;
  logic                  key_sel;
  logic [N_PARAMS*W-1:0] value_flat;
  logic [SW-1:0]         sel;
  logic [W-1:0]          gain_num;
  logic [W-1:0]          gain_den;
  logic                  update;

  modport master (
    output key_up, key_dn, key_sel,
    input  value_flat, sel, gain_num, gain_den, update
  );

  modport slave (
    input  key_up, key_dn, key_sel,
    output value_flat, sel, gain_num, gain_den, update
  );
endinterface

// File: rtl/effect_param_bank_controller.sv
// Push-button controller for a bank of N_PARAMS saturating effect parameters.
// Three active-low keys are synchronised (2 FF) and debounced; a debounced press steps the
// selected parameter up/down with saturation, or advances the selection.
// Optional feature: define AUTO_REPEAT_EN to auto-repeat a held up/dn key.
// Ports:
//   CLK : system clock
//   RST : synchronous active-high reset
//   bus : effect_param_bank_controller_if.slave (keys in; value_flat, sel, gain_num,
//         gain_den, update out)
module effect_param_bank_controller #(
  parameter int unsigned N_PARAMS        = 4,
  parameter int unsigned W               = 16,
  parameter int unsigned MIN_VAL         = 1,
  parameter int unsigned MAX_VAL         = 50,
  parameter int unsigned INIT_VAL        = 1,
  parameter int unsigned STEP            = 1,
  parameter int unsigned GAIN_DEN        = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 1000,
  parameter int unsigned REPEAT_PERIOD   = 250
) (
  input logic                         CLK,
  input logic                         RST,
  effect_param_bank_controller_if.slave bus
);
  localparam int unsigned SW = (N_PARAMS > 1) ? $clog2(N_PARAMS) : 1;
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned KUp  = 0;
  localparam int unsigned KDn  = 1;
  localparam int unsigned KSel = 2;

  localparam logic [W:0]   MaxW1  = (W+1)'(MAX_VAL);
  localparam logic [W:0]   MinW1  = (W+1)'(MIN_VAL);
  localparam logic [W:0]   StepW1 = (W+1)'(STEP);
  localparam logic [W-1:0] MaxW   = W'(MAX_VAL);
  localparam logic [W-1:0] MinW   = W'(MIN_VAL);
  localparam logic [W-1:0] StepW  = W'(STEP);

  logic [2:0]    raw;
  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    deb_q, deb_d;
  logic [2:0]    deb_prev_q;
  logic [DW-1:0] cnt_q [3];
  logic [DW-1:0] cnt_d [3];
  logic [2:0]    press;

  logic [W-1:0]  val_q [N_PARAMS];
  logic [W-1:0]  val_d [N_PARAMS];
  logic [SW-1:0] sel_q, sel_d;
  logic          update_q, update_d;

  logic          rpt_up, rpt_dn;
  logic          up_ev, dn_ev, sel_ev;
  logic [W-1:0]  cur, step_val;
  logic [W:0]    sum;

  assign raw = {bus.key_sel, bus.key_dn, bus.key_up};

  // Debounce: the accepted level only moves after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    deb_d = deb_q;
    for (int k = 0; k < 3; k++) begin
      cnt_d[k] = '0;
      if (sync2_q[k] != deb_q[k]) begin
        if (cnt_q[k] == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb_d[k] = sync2_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + DW'(1);
        end
      end
    end
  end

  // Falling edge of the debounced level; release produces nothing.
  assign press = deb_prev_q & ~deb_q;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW     = $clog2(RptMax + 1);

  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          rpt_phase_q, rpt_phase_d;
  logic          rpt_hold, rpt_fire;

  // Levels are active-low, so XOR is true when exactly one of up/dn is held.
  // The counter is 0 in the press-event cycle and counts cycles since the last step.
  always_comb begin
    rpt_hold    = deb_q[KUp] ^ deb_q[KDn];
    rpt_fire    = 1'b0;
    rpt_cnt_d   = '0;
    rpt_phase_d = 1'b0;
    if (rpt_hold) begin
      rpt_phase_d = rpt_phase_q;
      if (rpt_cnt_q == (rpt_phase_q ? RW'(REPEAT_PERIOD) : RW'(REPEAT_DELAY))) begin
        rpt_fire    = 1'b1;
        rpt_cnt_d   = RW'(1);
        rpt_phase_d = 1'b1;
      end else begin
        rpt_cnt_d = rpt_cnt_q + RW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rpt_cnt_q   <= '0;
      rpt_phase_q <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_phase_q <= rpt_phase_d;
    end
  end

  assign rpt_up = rpt_fire & ~deb_q[KUp];
  assign rpt_dn = rpt_fire & ~deb_q[KDn];
`else
  assign rpt_up = 1'b0;
  assign rpt_dn = 1'b0;
`endif

  assign up_ev  = press[KUp] | rpt_up;
  assign dn_ev  = press[KDn] | rpt_dn;
  assign sel_ev = press[KSel];

  // Step the old selection, then advance sel on the same edge.
  always_comb begin
    for (int i = 0; i < N_PARAMS; i++) begin
      val_d[i] = val_q[i];
    end
    sel_d    = sel_q;
    update_d = 1'b0;
    cur      = val_q[sel_q];
    sum      = {1'b0, cur} + StepW1;
    step_val = cur;
    if (up_ev && !dn_ev) begin
      step_val = (sum > MaxW1) ? MaxW : sum[W-1:0];
    end else if (dn_ev && !up_ev) begin
      step_val = ({1'b0, cur} < (MinW1 + StepW1)) ? MinW : (cur - StepW);
    end
    if (step_val != cur) begin
      val_d[sel_q] = step_val;
      update_d     = 1'b1;
    end
    if (sel_ev && (N_PARAMS > 1)) begin
      sel_d    = (sel_q == SW'(N_PARAMS - 1)) ? '0 : (sel_q + SW'(1));
      update_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      deb_q      <= '1;
      deb_prev_q <= '1;
      for (int k = 0; k < 3; k++) begin
        cnt_q[k] <= '0;
      end
      for (int i = 0; i < N_PARAMS; i++) begin
        val_q[i] <= W'(INIT_VAL);
      end
      sel_q    <= '0;
      update_q <= 1'b0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      for (int k = 0; k < 3; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
      for (int i = 0; i < N_PARAMS; i++) begin
        val_q[i] <= val_d[i];
      end
      sel_q    <= sel_d;
      update_q <= update_d;
    end
  end

  always_comb begin
    bus.value_flat = '0;
    for (int i = 0; i < N_PARAMS; i++) begin
      bus.value_flat[i*W +: W] = val_q[i];
    end
  end

  assign bus.sel      = sel_q;
  assign bus.gain_num = val_q[sel_q];
  assign bus.gain_den = W'(GAIN_DEN);
  assign bus.update   = update_q;
endmodule
